cr_osf_debug_seq: RTL and testbench

Sequencer for the OSF output-FIFO debug gating logic. It takes CSR mode-change and single-step commands and drives the applied debug mode and single-step read permission to the gating logic. Mode changes are applied only after any in-flight FIFO read has completed. A programmed number of single-step reads is metered out one FIFO read at a time. It sits between the OSF CSR block and the debug gating logic, in the OSF clock domain.

---
 rtl/cr_osf_debug_seq_pkg.sv | 33 +++
 rtl/cr_osf_debug_seq_if.sv | 43 ++++
 rtl/cr_osf_debug_seq.sv | 137 +++++++++++++
 tb/tb_cr_osf_debug_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cr_osf_debug_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | cr_osf_debug_seq_pkg : shared types for the OSF debug-mode sequencer     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package cr_osf_debug_seq_pkg;

   // Debug mode encodings consumed by the OSF output-FIFO gating logic.
   typedef enum logic [1:0] {
      OSF_DBG_NORMAL   = 2'd0,
      OSF_DBG_BLK_RDWR = 2'd1,
      OSF_DBG_BLK_RD   = 2'd2,
      OSF_DBG_SS       = 2'd3
   } osf_debug_mode_e;

   typedef enum logic [1:0] {
      SEQ_IDLE    = 2'd0,
      SEQ_STEP    = 2'd1,
      SEQ_QUIESCE = 2'd2,
      SEQ_APPLY   = 2'd3
   } osf_dbg_seq_state_e;

   // Width of the CSR single-step count field.
   localparam int C_STEP_CNT_W = 16;

   function automatic logic is_mode_busy_state(input osf_dbg_seq_state_e st);
      return (st == SEQ_QUIESCE) || (st == SEQ_APPLY);
   endfunction

endpackage : cr_osf_debug_seq_pkg

`default_nettype wire

// File: rtl/cr_osf_debug_seq_if.sv
// +--------------------------------------------------------------------------+
// | cr_osf_debug_seq_if : CSR / FIFO / gating-logic bundle of the sequencer  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface cr_osf_debug_seq_if #(
   parameter int STEP_CNT_W = 16
);
   logic [1:0]            cfg_mode_req;
   logic                  cfg_mode_req_vld;
   logic [STEP_CNT_W-1:0] cfg_step_cnt;
   logic                  cfg_step_go;
   logic                  fifo_hw_rd;
   logic                  fifo_empty;

   logic [1:0]            fifo_debug_mode;
   logic                  single_step_rd;
   logic                  mode_busy;
   logic [STEP_CNT_W-1:0] steps_remaining;
   logic                  step_done;
   logic                  step_abort;
   logic                  err_cmd;

   // Command / FIFO side (CSR block and FIFO read path).
   modport master (
      output cfg_mode_req, cfg_mode_req_vld, cfg_step_cnt, cfg_step_go,
      output fifo_hw_rd, fifo_empty,
      input  fifo_debug_mode, single_step_rd, mode_busy, steps_remaining,
      input  step_done, step_abort, err_cmd
   );

   // Sequencer side.
   modport slave (
      input  cfg_mode_req, cfg_mode_req_vld, cfg_step_cnt, cfg_step_go,
      input  fifo_hw_rd, fifo_empty,
      output fifo_debug_mode, single_step_rd, mode_busy, steps_remaining,
      output step_done, step_abort, err_cmd
   );

endinterface : cr_osf_debug_seq_if

`default_nettype wire

// File: rtl/cr_osf_debug_seq.sv
// +--------------------------------------------------------------------------+
// | cr_osf_debug_seq : applies CSR debug-mode changes after FIFO reads drain |
// | and meters out single-step read permission.           Revision: 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module cr_osf_debug_seq
   import cr_osf_debug_seq_pkg::*;
#(
   parameter int STEP_CNT_W = C_STEP_CNT_W
) (
   input  wire logic         clk,
   input  wire logic         rst,
   cr_osf_debug_seq_if.slave bus
);

   osf_dbg_seq_state_e    state_q,   state_d;
   osf_debug_mode_e       mode_q,    mode_d;
   osf_debug_mode_e       pend_q,    pend_d;
   logic [STEP_CNT_W-1:0] cnt_q,     cnt_d;
   logic                  done_q,    done_d;
   logic                  abort_q,   abort_d;
   logic                  err_q,     err_d;

   osf_debug_mode_e       w_req;
   logic                  w_ss_rd;
   logic                  w_step_rd;

   assign w_req     = osf_debug_mode_e'(bus.cfg_mode_req);
   assign w_ss_rd   = (state_q == SEQ_STEP) && (cnt_q != '0);
   assign w_step_rd = bus.fifo_hw_rd && w_ss_rd;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      abort_d = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         SEQ_IDLE: begin
            if (bus.cfg_mode_req_vld) begin
               if (w_req != mode_q) begin
                  pend_d  = w_req;
                  state_d = SEQ_QUIESCE;
               end
               // A mode request always takes precedence over a step arm.
               if (bus.cfg_step_go) begin
                  err_d = 1'b1;
               end
            end else if (bus.cfg_step_go) begin
               if ((mode_q == OSF_DBG_SS) && (bus.cfg_step_cnt != '0)) begin
                  cnt_d   = bus.cfg_step_cnt;
                  state_d = SEQ_STEP;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         SEQ_STEP: begin
            if (bus.cfg_step_go) begin
               err_d = 1'b1;
            end
            if (bus.cfg_mode_req_vld) begin
               pend_d  = w_req;
               cnt_d   = '0;
               abort_d = 1'b1;
               state_d = SEQ_QUIESCE;
            end else if (w_step_rd) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == {{(STEP_CNT_W-1){1'b0}}, 1'b1}) begin
                  done_d  = 1'b1;
                  state_d = SEQ_IDLE;
               end
            end
         end

         SEQ_QUIESCE: begin
            if (bus.cfg_mode_req_vld) begin
               pend_d = w_req;
            end
            if (bus.cfg_step_go) begin
               err_d = 1'b1;
            end
            if (!bus.fifo_hw_rd) begin
               state_d = SEQ_APPLY;
            end
         end

         SEQ_APPLY: begin
            mode_d  = pend_q;
            state_d = SEQ_IDLE;
            if (bus.cfg_mode_req_vld || bus.cfg_step_go) begin
               err_d = 1'b1;
            end
         end

         default: begin
            state_d = SEQ_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEQ_IDLE;
         mode_q  <= OSF_DBG_NORMAL;
         pend_q  <= OSF_DBG_NORMAL;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         abort_q <= abort_d;
         err_q   <= err_d;
      end
   end

   assign bus.fifo_debug_mode = mode_q;
   assign bus.single_step_rd  = w_ss_rd;
   assign bus.mode_busy       = is_mode_busy_state(state_q);
   assign bus.steps_remaining = cnt_q;
   assign bus.step_done       = done_q;
   assign bus.step_abort      = abort_q;
   assign bus.err_cmd         = err_q;

endmodule : cr_osf_debug_seq

`default_nettype wire

// File: tb/tb_cr_osf_debug_seq.sv
// +--------------------------------------------------------------------------+
// | tb_cr_osf_debug_seq : directed self-checking bench for cr_osf_debug_seq  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cr_osf_debug_seq;

   localparam int C_W = 16;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   cr_osf_debug_seq_if #(.STEP_CNT_W(C_W)) bus ();

   cr_osf_debug_seq #(.STEP_CNT_W(C_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cfg_mode_req     = 2'd0;
      bus.cfg_mode_req_vld = 1'b0;
      bus.cfg_step_cnt     = '0;
      bus.cfg_step_go      = 1'b0;
      bus.fifo_hw_rd       = 1'b0;
   endtask

   task automatic mode_req(input logic [1:0] m);
      bus.cfg_mode_req     = m;
      bus.cfg_mode_req_vld = 1'b1;
      tick();
      bus.cfg_mode_req_vld = 1'b0;
   endtask

   task automatic step_go(input logic [C_W-1:0] n);
      bus.cfg_step_cnt = n;
      bus.cfg_step_go  = 1'b1;
      tick();
      bus.cfg_step_go  = 1'b0;
   endtask

   task automatic read_once();
      bus.fifo_hw_rd = 1'b1;
      tick();
      bus.fifo_hw_rd = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle_inputs();
      bus.fifo_empty = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      check("rst_mode",  bus.fifo_debug_mode, 2'd0);
      check("rst_busy",  bus.mode_busy,       1'b0);
      check("rst_ssrd",  bus.single_step_rd,  1'b0);
      check("rst_steps", bus.steps_remaining, 0);
      check("rst_pulse", {bus.step_done, bus.step_abort, bus.err_cmd}, 3'b000);
      rst = 1'b0;
      tick();

      // Mode change with no read in flight: 2-cycle latency.
      mode_req(2'd3);
      check("m3_busy_c1", bus.mode_busy,       1'b1);
      check("m3_mode_c1", bus.fifo_debug_mode, 2'd0);
      check("m3_err_c1",  bus.err_cmd,         1'b0);
      tick();
      check("m3_busy_c2", bus.mode_busy,       1'b1);
      check("m3_mode_c2", bus.fifo_debug_mode, 2'd0);
      tick();
      check("m3_mode_c3", bus.fifo_debug_mode, 2'd3);
      check("m3_busy_c3", bus.mode_busy,       1'b0);
      check("m3_err_c3",  bus.err_cmd,         1'b0);

      // Same-mode request is a silent no-op.
      mode_req(2'd3);
      check("same_busy", bus.mode_busy, 1'b0);
      check("same_err",  bus.err_cmd,   1'b0);

      // Four non-consecutive single-step reads.
      step_go(16'd4);
      check("s4_steps", bus.steps_remaining, 4);
      check("s4_ssrd",  bus.single_step_rd,  1'b1);
      check("s4_err",   bus.err_cmd,         1'b0);
      for (int i = 0; i < 4; i++) begin
         read_once();
         check("s4_cnt",  bus.steps_remaining, 3 - i);
         check("s4_done", bus.step_done,       (i == 3) ? 1'b1 : 1'b0);
         check("s4_ssrd", bus.single_step_rd,  (i == 3) ? 1'b0 : 1'b1);
         tick();
         check("s4_done_gap", bus.step_done, 1'b0);
      end

      // Abort of an armed step sequence by a mode change.
      step_go(16'd5);
      read_once();
      read_once();
      check("ab_steps2", bus.steps_remaining, 3);
      mode_req(2'd0);
      check("ab_abort",  bus.step_abort,      1'b1);
      check("ab_steps",  bus.steps_remaining, 0);
      check("ab_ssrd",   bus.single_step_rd,  1'b0);
      check("ab_done",   bus.step_done,       1'b0);
      check("ab_busy",   bus.mode_busy,       1'b1);
      tick();
      check("ab_abort2", bus.step_abort,      1'b0);
      tick();
      check("ab_mode",   bus.fifo_debug_mode, 2'd0);
      check("ab_busy2",  bus.mode_busy,       1'b0);

      // Quiesce held by an in-flight read; later request in QUIESCE wins.
      bus.fifo_hw_rd = 1'b1;
      mode_req(2'd2);
      check("q_busy1", bus.mode_busy,       1'b1);
      mode_req(2'd1);
      check("q_mode2", bus.fifo_debug_mode, 2'd0);
      bus.fifo_hw_rd = 1'b0;
      tick();
      check("q_busy4", bus.mode_busy,       1'b1);
      check("q_mode4", bus.fifo_debug_mode, 2'd0);
      bus.cfg_mode_req = 2'd3;
      bus.cfg_mode_req_vld = 1'b1;
      tick();
      bus.cfg_mode_req_vld = 1'b0;
      check("q_err_apply", bus.err_cmd,         1'b1);
      check("q_mode5",     bus.fifo_debug_mode, 2'd1);
      check("q_busy5",     bus.mode_busy,       1'b0);
      tick();
      check("q_dropped",   bus.mode_busy,       1'b0);
      check("q_mode6",     bus.fifo_debug_mode, 2'd1);

      // Rejected step commands.
      step_go(16'd3);
      check("rej_mode_err",   bus.err_cmd,         1'b1);
      check("rej_mode_steps", bus.steps_remaining, 0);
      mode_req(2'd3);
      tick();
      tick();
      check("rej_m3", bus.fifo_debug_mode, 2'd3);
      step_go(16'd0);
      check("rej_zero_err",  bus.err_cmd,        1'b1);
      check("rej_zero_ssrd", bus.single_step_rd, 1'b0);
      step_go(16'd2);
      check("rej_arm_err",   bus.err_cmd,         1'b0);
      check("rej_arm_steps", bus.steps_remaining, 2);
      step_go(16'd9);
      check("rej_step_err",   bus.err_cmd,         1'b1);
      check("rej_step_steps", bus.steps_remaining, 2);
      bus.fifo_hw_rd = 1'b1;
      tick();
      check("bb_steps1", bus.steps_remaining, 1);
      tick();
      bus.fifo_hw_rd = 1'b0;
      check("bb_steps0", bus.steps_remaining, 0);
      check("bb_done",   bus.step_done,       1'b1);
      check("bb_ssrd",   bus.single_step_rd,  1'b0);

      // Simultaneous mode request and step arm in IDLE.
      bus.cfg_step_cnt = 16'd4;
      bus.cfg_step_go  = 1'b1;
      mode_req(2'd0);
      bus.cfg_step_go  = 1'b0;
      check("sim_err",   bus.err_cmd,         1'b1);
      check("sim_busy",  bus.mode_busy,       1'b1);
      check("sim_steps", bus.steps_remaining, 0);
      tick();
      tick();
      check("sim_mode", bus.fifo_debug_mode, 2'd0);
      mode_req(2'd3);
      tick();
      tick();

      // Reset in the middle of a step sequence.
      step_go(16'd7);
      read_once();
      check("rs_steps6", bus.steps_remaining, 6);
      rst = 1'b1;
      bus.fifo_hw_rd = 1'b1;
      bus.cfg_step_go = 1'b1;
      bus.cfg_step_cnt = 16'd1;
      tick();
      idle_inputs();
      check("rs_mode",  bus.fifo_debug_mode, 2'd0);
      check("rs_ssrd",  bus.single_step_rd,  1'b0);
      check("rs_steps", bus.steps_remaining, 0);
      check("rs_busy",  bus.mode_busy,       1'b0);
      check("rs_pulse", {bus.step_done, bus.step_abort, bus.err_cmd}, 3'b000);
      rst = 1'b0;
      tick();
      check("rs_pulse2", {bus.step_done, bus.step_abort, bus.err_cmd}, 3'b000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_cr_osf_debug_seq

`default_nettype wire
